// File: rtl/dffn_scan_chain_ctrl_if.sv
// Control/observe bundle between the scan-chain sequencer and its host/chain side.
// The host drives the request and returns the chain's SO. The sequencer drives the chain controls and status.
interface dffn_scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned IDX_W     = $clog2(CHAIN_LEN)
);
  logic                 START;
  logic                 MODE;
  logic [CHAIN_LEN-1:0] PATTERN;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic                 CHAIN_RN;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [IDX_W-1:0]     FAIL_IDX;

  modport master (
    output START, MODE, PATTERN, SO,
    input  SE, SI, CHAIN_RN, BUSY, DONE, PASS, FAIL_IDX
  );

  modport slave (
    input  START, MODE, PATTERN, SO,
    output SE, SI, CHAIN_RN, BUSY, DONE, PASS, FAIL_IDX
  );
endinterface

// File: rtl/dffn_scan_chain_ctrl.sv
// Sequencer for self-test of a falling-edge scan chain: load a pattern, optionally pulse the
// chain reset, then unload and compare. All chain controls come straight from flops.
module dffn_scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned RST_CYC   = 2,
  parameter int unsigned IDX_W     = $clog2(CHAIN_LEN)
) (
  input logic                   CLK,
  input logic                   RST,
  dffn_scan_chain_ctrl_if.slave bus
);

  localparam int unsigned CntMax = (CHAIN_LEN > RST_CYC) ? CHAIN_LEN : RST_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StApply, StUnload, StFin} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic                 mode_q, mode_d;
  logic                 ok_q, ok_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 rn_q, rn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [IDX_W-1:0]     fidx_q, fidx_d;
  logic                 cmp_en;
  logic [IDX_W-1:0]     cmp_idx;
  logic                 exp_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    ok_d    = ok_q;
    se_d    = se_q;
    si_d    = si_q;
    rn_d    = rn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    cmp_en  = 1'b0;
    cmp_idx = '0;

    // The chain shifts on the falling edge, so SO already carries unload bit j at the rising
    // edge that opens unload cycle j; that is where bit j is compared.
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StLoad;
          cnt_d   = CntW'(1);
          pat_d   = bus.PATTERN;
          mode_d  = bus.MODE;
          ok_d    = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fidx_d  = '0;
          se_d    = 1'b1;
          si_d    = bus.PATTERN[0];
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(CHAIN_LEN)) begin
          si_d = 1'b0;
          if (mode_q) begin
            state_d = StApply;
            cnt_d   = CntW'(1);
            se_d    = 1'b0;
            rn_d    = 1'b0;
          end else begin
            state_d = StUnload;
            cnt_d   = '0;
            cmp_en  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          si_d  = pat_q[IDX_W'(cnt_q)];
        end
      end
      StApply: begin
        if (cnt_q == CntW'(RST_CYC)) begin
          state_d = StUnload;
          cnt_d   = '0;
          se_d    = 1'b1;
          rn_d    = 1'b1;
          cmp_en  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StUnload: begin
        if (cnt_q == CntW'(CHAIN_LEN - 1)) begin
          state_d = StFin;
          se_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ok_q;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          cmp_en  = 1'b1;
          cmp_idx = IDX_W'(cnt_q + 1'b1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    exp_bit = mode_q ? 1'b0 : pat_q[cmp_idx];
    if (cmp_en && ok_q && (bus.SO != exp_bit)) begin
      ok_d   = 1'b0;
      fidx_d = cmp_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
      mode_q  <= 1'b0;
      ok_q    <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      rn_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      ok_q    <= ok_d;
      se_q    <= se_d;
      si_q    <= si_d;
      rn_q    <= rn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
    end
  end

  assign bus.SE       = se_q;
  assign bus.SI       = si_q;
  assign bus.CHAIN_RN = rn_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.FAIL_IDX = fidx_q;

endmodule
